// File: rtl/alu_sched_pkg.sv
// Shared definitions for the ALU operation scheduler.
//   - state_t    : scheduler FSM states
//   - UNIT_*     : unit-select codes carried in alu_fun[3:2]
//   - DEF_*      : default widths and timeout
//   - unit_of()  : extracts the unit-select field from a function code
package alu_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10,
    ST_RESP  = 2'b11
  } state_t;

  localparam logic [1:0] UNIT_ARITH = 2'b00;
  localparam logic [1:0] UNIT_LOGIC = 2'b01;
  localparam logic [1:0] UNIT_CMP   = 2'b10;
  localparam logic [1:0] UNIT_SHIFT = 2'b11;

  localparam int DEF_OPERAND_WIDTH = 16;
  localparam int DEF_ALU_FUN_WIDTH = 4;
  localparam int DEF_TIMEOUT       = 8;

  function automatic logic [1:0] unit_of(input logic [3:0] fun);
    return fun[3:2];
  endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter (purely combinational).
//   valid[1:0]  in   request lines
//   last_grant  in   index of the requester granted most recently
//   grant[1:0]  out  one-hot grant, all zero when nothing is valid
module rr_arbiter_2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant
);

  // A requester wins if it is alone, or on a tie if it was not the last winner.
  for (genvar gi = 0; gi < 2; gi++) begin : g_grant
    assign grant[gi] = valid[gi] && (!valid[1-gi] || (last_grant != 1'(gi)));
  end

endmodule

// File: rtl/alu_op_scheduler.sv
// Shares one ALU between two requesters, one operation in flight at a time.
// Accepts an op (round-robin between requesters), issues it to the ALU with
// a one-cycle enable strobe, waits for the result (or a timeout) and returns
// it tagged with the owning requester's id.
//   CLK, RST                 clock, synchronous active-low reset
//   reqN_valid/ready/a/b/fun request channel per requester (N = 0, 1)
//   alu_a/b/fun, alu_enable  registered operation towards the ALU
//   alu_out, alu_out_valid   result from the ALU
//   rsp_valid/ready/id/data/err  response channel (data 0 and err 1 on timeout)
//   busy                     high whenever the scheduler is not idle
module alu_op_scheduler
  import alu_sched_pkg::*;
#(
  parameter int OPERAND_WIDTH = DEF_OPERAND_WIDTH,
  parameter int ALU_FUN_WIDTH = DEF_ALU_FUN_WIDTH,
  parameter int TIMEOUT       = DEF_TIMEOUT
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     req0_valid,
  output logic                     req0_ready,
  input  logic [OPERAND_WIDTH-1:0] req0_a,
  input  logic [OPERAND_WIDTH-1:0] req0_b,
  input  logic [ALU_FUN_WIDTH-1:0] req0_fun,
  input  logic                     req1_valid,
  output logic                     req1_ready,
  input  logic [OPERAND_WIDTH-1:0] req1_a,
  input  logic [OPERAND_WIDTH-1:0] req1_b,
  input  logic [ALU_FUN_WIDTH-1:0] req1_fun,
  output logic [OPERAND_WIDTH-1:0] alu_a,
  output logic [OPERAND_WIDTH-1:0] alu_b,
  output logic [ALU_FUN_WIDTH-1:0] alu_fun,
  output logic                     alu_enable,
  input  logic [OPERAND_WIDTH-1:0] alu_out,
  input  logic                     alu_out_valid,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic                     rsp_id,
  output logic [OPERAND_WIDTH-1:0] rsp_data,
  output logic                     rsp_err,
  output logic                     busy
);

  localparam int TW = $clog2(TIMEOUT);

  state_t                   state_reg, state_next;
  logic                     last_grant_reg;
  logic [TW-1:0]            timer_reg;
  logic [OPERAND_WIDTH-1:0] a_reg, b_reg, data_reg;
  logic [ALU_FUN_WIDTH-1:0] fun_reg;
  logic                     id_reg, err_reg;
  logic [1:0]               grant;
  logic                     timeout_hit;

  rr_arbiter_2 u_arb (
    .valid      ({req1_valid, req0_valid}),
    .last_grant (last_grant_reg),
    .grant      (grant)
  );

  assign timeout_hit = (timer_reg == TW'(TIMEOUT - 1));

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    alu_enable = 1'b0;
    rsp_valid  = 1'b0;
    busy       = 1'b1;
    case (state_reg)
      ST_IDLE: begin
        busy = 1'b0;
        // Ready is gated by RST so no handshake is advertised while reset holds.
        req0_ready = RST && grant[0];
        req1_ready = RST && grant[1];
        if (|grant) state_next = ST_ISSUE;
      end
      ST_ISSUE: begin
        alu_enable = 1'b1;
        state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (alu_out_valid || timeout_hit) state_next = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      last_grant_reg <= 1'b1;
      timer_reg      <= '0;
      a_reg          <= '0;
      b_reg          <= '0;
      fun_reg        <= '0;
      id_reg         <= 1'b0;
      data_reg       <= '0;
      err_reg        <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (|grant) begin
            a_reg          <= grant[1] ? req1_a   : req0_a;
            b_reg          <= grant[1] ? req1_b   : req0_b;
            fun_reg        <= grant[1] ? req1_fun : req0_fun;
            id_reg         <= grant[1];
            last_grant_reg <= grant[1];
          end
        end
        ST_ISSUE: timer_reg <= '0;
        ST_WAIT: begin
          timer_reg <= timer_reg + TW'(1);
          // A result arriving on the timeout cycle still counts as a result.
          if (alu_out_valid) begin
            data_reg <= alu_out;
            err_reg  <= 1'b0;
          end else if (timeout_hit) begin
            data_reg <= '0;
            err_reg  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign alu_a    = a_reg;
  assign alu_b    = b_reg;
  assign alu_fun  = fun_reg;
  assign rsp_id   = id_reg;
  assign rsp_data = data_reg;
  assign rsp_err  = err_reg;

endmodule
